// File: rtl/bzled_seq.sv
// bzled_seq - LED/buzzer pattern sequencer
//
// Plays a small table of entries. Each entry holds R/G/B PWM duty, a buzzer
// frequency and a duration in ticks. One tick is TICK_DIV clock cycles.
// The Set outputs drive the LED/buzzer PWM peripheral. Each entry's outputs
// are held for 1 + max(DUR,1)*TICK_DIV cycles, and there is no gap between
// entries.
//
// Ports
//   CLK, RST                    clock and synchronous active-high reset
//   WR_EN/WR_ADDR/WR_SEL/WR_DATA table write port
//                                 (sel 0..4 = R, G, B, BZ freq, DUR[15:0])
//   START, STOP                 run pulse, abort pulse
//   LOOP                        repeat the sequence after LAST_IDX (level)
//   LAST_IDX                    last entry played, latched at START
//   LED?_Puty_Set, BZ_FREQ_Set  PWM settings for the current entry
//   BZ_GATE                     buzzer enable, set when BZ freq is non-zero
//   BUSY, DONE, CUR_IDX         status: active, completion pulse, entry index
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | outputs zero, waiting for START
// LOAD   | one cycle; the exit edge registers table[idx] (or, when
//        | fin_q is set, clears the outputs and pulses DONE)
// RUN    | outputs held while the tick/duration down-counters run
//
// The final cycle of the last entry is spent in LOAD with fin_q set. This
// gives the last entry the same 1 + N*TICK_DIV hold time as the other
// entries, and BUSY falls on the same edge that clears the outputs.

module bzled_seq #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [$clog2(DEPTH)-1:0] WR_ADDR,
  input  logic [2:0]               WR_SEL,
  input  logic [31:0]              WR_DATA,
  input  logic                     START,
  input  logic                     STOP,
  input  logic                     LOOP,
  input  logic [$clog2(DEPTH)-1:0] LAST_IDX,
  output logic [31:0]              LEDR_Puty_Set,
  output logic [31:0]              LEDG_Puty_Set,
  output logic [31:0]              LEDB_Puty_Set,
  output logic [31:0]              BZ_FREQ_Set,
  output logic                     BZ_GATE,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [$clog2(DEPTH)-1:0] CUR_IDX
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] r_tab [DEPTH];
  logic [31:0] g_tab [DEPTH];
  logic [31:0] b_tab [DEPTH];
  logic [31:0] f_tab [DEPTH];
  logic [15:0] d_tab [DEPTH];

  logic [AW-1:0] idx_q;
  logic [AW-1:0] last_q;
  logic          fin_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   dur_q;
  logic          done_q;
  logic          gate_q;
  logic [31:0]   r_q, g_q, b_q, f_q;
  logic [AW-1:0] cur_q;

  logic          tick;
  logic          entry_end;
  logic          is_last;
  logic          accept;
  logic          load_fire;
  logic          finish;
  logic          advance;
  logic          wrap;
  logic          end_last;
  logic [15:0]   dur_load;

  // Table write port. Reset clears every field.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tab[i] <= '0;
        g_tab[i] <= '0;
        b_tab[i] <= '0;
        f_tab[i] <= '0;
        d_tab[i] <= '0;
      end
    end else if (WR_EN) begin
      case (WR_SEL)
        3'd0:    r_tab[WR_ADDR] <= WR_DATA;
        3'd1:    g_tab[WR_ADDR] <= WR_DATA;
        3'd2:    b_tab[WR_ADDR] <= WR_DATA;
        3'd3:    f_tab[WR_ADDR] <= WR_DATA;
        3'd4:    d_tab[WR_ADDR] <= WR_DATA[15:0];
        default: ;
      endcase
    end
  end

  // Both timers count down and fire on their terminal count. A tick fires
  // when the prescaler reaches 0. The entry ends on the tick that finds
  // the duration counter at 1.
  assign tick      = (state_q == S_RUN) && (presc_q == '0);
  assign entry_end = tick && (dur_q == 16'd1);
  assign is_last   = (idx_q == last_q);
  assign dur_load  = (d_tab[idx_q] == 16'd0) ? 16'd1 : d_tab[idx_q];

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_fire = 1'b0;
    finish    = 1'b0;
    advance   = 1'b0;
    wrap      = 1'b0;
    end_last  = 1'b0;
    if (STOP) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_LOAD;
            accept  = 1'b1;
          end
        end
        S_LOAD: begin
          if (fin_q) begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_d   = S_RUN;
            load_fire = 1'b1;
          end
        end
        S_RUN: begin
          if (entry_end) begin
            state_d = S_LOAD;
            if (!is_last)  advance  = 1'b1;
            else if (LOOP) wrap     = 1'b1;
            else           end_last = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q   <= '0;
      last_q  <= '0;
      fin_q   <= 1'b0;
      presc_q <= '0;
      dur_q   <= '0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      cur_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (STOP) begin
        idx_q   <= '0;
        fin_q   <= 1'b0;
        presc_q <= '0;
        dur_q   <= '0;
        gate_q  <= 1'b0;
        r_q     <= '0;
        g_q     <= '0;
        b_q     <= '0;
        f_q     <= '0;
        cur_q   <= '0;
      end else begin
        if (accept) begin
          idx_q  <= '0;
          last_q <= LAST_IDX;
          fin_q  <= 1'b0;
        end
        // Outputs are a snapshot of the table, so a rewrite of the playing
        // entry only shows up the next time that entry is loaded.
        if (load_fire) begin
          r_q     <= r_tab[idx_q];
          g_q     <= g_tab[idx_q];
          b_q     <= b_tab[idx_q];
          f_q     <= f_tab[idx_q];
          gate_q  <= (f_tab[idx_q] != 32'd0);
          cur_q   <= idx_q;
          presc_q <= PRESC_MAX;
          dur_q   <= dur_load;
        end
        if (finish) begin
          idx_q  <= '0;
          fin_q  <= 1'b0;
          done_q <= 1'b1;
          gate_q <= 1'b0;
          r_q    <= '0;
          g_q    <= '0;
          b_q    <= '0;
          f_q    <= '0;
          cur_q  <= '0;
        end
        if (state_q == S_RUN) begin
          presc_q <= tick ? PRESC_MAX : presc_q - 1'b1;
          if (tick && (dur_q != 16'd1)) dur_q <= dur_q - 1'b1;
        end
        if (advance)  idx_q <= idx_q + 1'b1;
        if (wrap)     idx_q <= '0;
        if (end_last) fin_q <= 1'b1;
      end
    end
  end

  assign LEDR_Puty_Set = r_q;
  assign LEDG_Puty_Set = g_q;
  assign LEDB_Puty_Set = b_q;
  assign BZ_FREQ_Set   = f_q;
  assign BZ_GATE       = gate_q;
  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = done_q;
  assign CUR_IDX       = cur_q;

endmodule

// File: tb/tb_bzled_seq.sv
module tb_bzled_seq;
  localparam int DEPTH = 8;
  localparam int TD    = 4;

  logic        CLK = 1'b0;
  logic        RST, WR_EN, START, STOP, LOOP;
  logic [2:0]  WR_ADDR, WR_SEL, LAST_IDX;
  logic [31:0] WR_DATA;
  logic [31:0] LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set, BZ_FREQ_Set;
  logic        BZ_GATE, BUSY, DONE;
  logic [2:0]  CUR_IDX;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_r [DEPTH];
  logic [31:0] m_g [DEPTH];
  logic [31:0] m_b [DEPTH];
  logic [31:0] m_f [DEPTH];
  logic [15:0] m_d [DEPTH];

  typedef struct packed {
    logic [31:0] r, g, b, f;
    logic        gate;
    logic [2:0]  cur;
    logic        busy;
    logic        done;
  } obs_t;

  bzled_seq #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_SEL(WR_SEL),
    .WR_DATA(WR_DATA), .START(START), .STOP(STOP), .LOOP(LOOP),
    .LAST_IDX(LAST_IDX), .LEDR_Puty_Set(LEDR_Puty_Set),
    .LEDG_Puty_Set(LEDG_Puty_Set), .LEDB_Puty_Set(LEDB_Puty_Set),
    .BZ_FREQ_Set(BZ_FREQ_Set), .BZ_GATE(BZ_GATE), .BUSY(BUSY), .DONE(DONE),
    .CUR_IDX(CUR_IDX)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.r = LEDR_Puty_Set; o.g = LEDG_Puty_Set; o.b = LEDB_Puty_Set;
    o.f = BZ_FREQ_Set; o.gate = BZ_GATE; o.cur = CUR_IDX;
    o.busy = BUSY; o.done = DONE;
    return o;
  endfunction

  task automatic wr(input int a, input int sel, input logic [31:0] d);
    WR_EN = 1'b1; WR_ADDR = a[2:0]; WR_SEL = sel[2:0]; WR_DATA = d;
    case (sel)
      0: m_r[a] = d;
      1: m_g[a] = d;
      2: m_b[a] = d;
      3: m_f[a] = d;
      4: m_d[a] = d[15:0];
      default: ;
    endcase
    step();
    WR_EN = 1'b0;
  endtask

  task automatic set_entry(input int a, input logic [31:0] r, input logic [31:0] g,
                           input logic [31:0] b, input logic [31:0] f, input logic [31:0] d);
    wr(a, 0, r); wr(a, 1, g); wr(a, 2, b); wr(a, 3, f); wr(a, 4, d);
  endtask

  function automatic int hold_of(input int k);
    return 1 + ((m_d[k] == 16'd0) ? 1 : int'(m_d[k])) * TD;
  endfunction

  // Starts a sequence and predicts every cycle from the hold-time rule.
  // poke: 1 = START pulse, 2 = rewrite entry1 R=99, 3 = LAST_IDX -> 5.
  task automatic play(input string nm, input int last, input bit loop, input int ncyc,
                      input int stop_c, input int poke_c, input int poke);
    obs_t e, a;
    int k = 0, left = 0, phase = 0;
    bit stopped = 0, nxt;
    logic [31:0] sr = 0, sg = 0, sb = 0, sf = 0;
    LAST_IDX = last[2:0]; LOOP = loop; START = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      nxt = 0;
      if (c > 0 && !stopped) begin
        case (phase)
          0: begin k = 0; nxt = 1; end
          1: begin
            left--;
            if (left == 0) begin
              if (k != last)  begin k++; nxt = 1; end
              else if (loop)  begin k = 0; nxt = 1; end
              else            phase = 2;
            end
          end
          2: phase = 3;
          default: ;
        endcase
        if (nxt) begin
          phase = 1; left = hold_of(k);
          sr = m_r[k]; sg = m_g[k]; sb = m_b[k]; sf = m_f[k];
        end
      end
      if (stopped) phase = 3;
      e = '0;
      if (phase == 0) e.busy = 1'b1;
      else if (phase == 1) begin
        e.r = sr; e.g = sg; e.b = sb; e.f = sf; e.gate = (sf != 0);
        e.cur = k[2:0]; e.busy = 1'b1;
      end else if (phase == 2) e.done = 1'b1;
      a = sample();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got %h required %h", nm, c, a, e);
      end
      if (c == stop_c) begin STOP = 1'b1; stopped = 1; end
      if (c == poke_c) begin
        case (poke)
          1: START = 1'b1;
          2: begin WR_EN = 1'b1; WR_ADDR = 3'd1; WR_SEL = 3'd0; WR_DATA = 32'd99; m_r[1] = 32'd99; end
          3: LAST_IDX = 3'd5;
          default: ;
        endcase
      end
      step();
      START = 1'b0; STOP = 1'b0; WR_EN = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t a;
    RST = 1'b1; START = 1'b1; LAST_IDX = 3'd0;
    step();
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin
      n_bad++; $display("FAIL reset_state: got %h required 0", a);
    end
    RST = 1'b0;
    step();
    START = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b1 || CUR_IDX !== 3'd0 || LEDR_Puty_Set !== 32'd0) begin
      n_bad++; $display("FAIL start_after_reset: got busy=%b cur=%0d r=%0h required busy=1 cur=0 r=0", BUSY, CUR_IDX, LEDR_Puty_Set);
    end
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL stop_in_load: got busy=%b done=%b required 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_single();
    set_entry(0, 32'd10, 32'd20, 32'd30, 32'd500, 32'd2);
    wr(0, 7, 32'hdeadbeef);
    wr(0, 5, 32'h12345678);
    play("single", 0, 0, 14, -1, -1, 0);
  endtask

  task automatic load_three();
    set_entry(0, $urandom, $urandom, $urandom, $urandom_range(1, 5000), 32'd1);
    set_entry(1, 32'd7,    $urandom, $urandom, $urandom_range(1, 5000), 32'd0);
    set_entry(2, $urandom, $urandom, $urandom, $urandom_range(1, 5000), 32'd3);
  endtask

  task automatic test_loop_stop();
    load_three();
    play("loop_stop", 2, 1, 44, 38, -1, 0);
  endtask

  task automatic test_start_stop_idle();
    obs_t a;
    START = 1'b1; STOP = 1'b1; LAST_IDX = 3'd2;
    step();
    START = 1'b0; STOP = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = sample();
      n_cmp++;
      if (a !== obs_t'(0)) begin
        n_bad++; $display("FAIL start_stop_idle cyc %0d: got %h required 0", i, a);
      end
      step();
    end
  endtask

  task automatic test_start_during_run();
    load_three();
    play("start_in_run", 2, 0, 27, -1, 8, 1);
  endtask

  task automatic test_rewrite();
    load_three();
    play("rewrite", 2, 1, 40, 36, 7, 2);
  endtask

  task automatic test_lastidx_bz0();
    load_three();
    wr(2, 3, 32'd0);
    play("last_chg_bz0", 2, 0, 27, -1, 10, 3);
  endtask

  task automatic test_reset_mid_run();
    obs_t a;
    load_three();
    LAST_IDX = 3'd2; LOOP = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    repeat (6) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin
      n_bad++; $display("FAIL reset_mid_run: got %h required 0", a);
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_f[i] = 0; m_d[i] = 0;
    end
    play("after_reset", 2, 0, 20, -1, -1, 0);
  endtask

  task automatic test_random();
    int last, ncyc;
    for (int it = 0; it < 4; it++) begin
      last = $urandom_range(0, 7);
      for (int k = 0; k <= last; k++)
        set_entry(k, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  ($urandom << 16) | $urandom_range(0, 3));
      wr($urandom_range(0, 7), $urandom_range(5, 7), $urandom);
      ncyc = 4;
      for (int k = 0; k <= last; k++) ncyc += hold_of(k);
      play("random", last, 0, ncyc, -1, -1, 0);
    end
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_SEL = '0; WR_DATA = '0;
    START = 1'b0; STOP = 1'b0; LOOP = 1'b0; LAST_IDX = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_f[i] = 0; m_d[i] = 0;
    end
    step();
    test_reset();
    test_single();
    test_loop_stop();
    test_start_stop_idle();
    test_start_during_run();
    test_rewrite();
    test_lastidx_bz0();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
